// File: rtl/tt_um_ternary_mvm_stream_if.sv
// Streaming handshake bundle for the ternary MVM engine: activation beats in, result elements out.
// master = producer/consumer side, slave = engine side.
interface tt_um_ternary_mvm_stream_if #(
  parameter int BitWidth = 8,
  parameter int LanesIn  = 2,
  parameter int OutLen   = 8
);
  localparam int IdxW = (OutLen > 1) ? $clog2(OutLen) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [LanesIn*BitWidth-1:0] vec_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [BitWidth-1:0]         vec_out;
  logic [IdxW-1:0]             out_idx;

  modport master (
    output in_valid, vec_in, out_ready,
    input  in_ready, out_valid, vec_out, out_idx
  );

  modport slave (
    input  in_valid, vec_in, out_ready,
    output in_ready, out_valid, vec_out, out_idx
  );
endinterface

// File: rtl/tt_um_ternary_mvm_stream.sv
// Ternary-weight matrix-vector engine: LanesIn activations per beat into OutLen accumulators,
// then drains saturated (optionally ReLU'd) results one per beat; first result 1 clk after last beat.
module tt_um_ternary_mvm_stream #(
  parameter int InLen    = 16,
  parameter int OutLen   = 8,
  parameter int BitWidth = 8,
  parameter int LanesIn  = 2,
  parameter int AccWidth = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        relu_en,
  input  logic [2*InLen*OutLen-1:0]   W,
  tt_um_ternary_mvm_stream_if.slave   strm,
  output logic                        busy,
  output logic                        overflow
);
  localparam int NBEATS = InLen / LanesIn;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IdxW   = (OutLen > 1) ? $clog2(OutLen) : 1;

  localparam logic signed [AccWidth-1:0] SMAX =
    {{(AccWidth-BitWidth+1){1'b0}}, {(BitWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] SMIN =
    {{(AccWidth-BitWidth+1){1'b1}}, {(BitWidth-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                      state_q, state_d;
  logic [BCW-1:0]              beat_q;
  logic [IdxW-1:0]             idx_q, idx_nx;
  logic                        relu_q, relu_eff;
  logic [BitWidth-1:0]         vout_q;
  logic                        clamp_q;
  logic signed [AccWidth-1:0]  acc_q    [OutLen];
  logic signed [AccWidth-1:0]  acc_next [OutLen];
  logic signed [AccWidth-1:0]  sel_acc;
  logic [BitWidth:0]           sel_sat;
  logic [BitWidth-1:0]         sel_res;
  logic                        accept, out_fire, last_beat, last_out;

  function automatic logic signed [AccWidth-1:0] term(
    input logic [BitWidth-1:0] x,
    input logic [1:0]          code
  );
    logic signed [AccWidth-1:0] xe;
    xe = {{(AccWidth-BitWidth){x[BitWidth-1]}}, x};
    case (code)
      2'b01:   return xe;
      2'b11:   return -xe;
      default: return '0;
    endcase
  endfunction

  // MSB of the result flags that clamping was needed
  function automatic logic [BitWidth:0] sat(input logic signed [AccWidth-1:0] a);
    if (a > SMAX)      return {1'b1, SMAX[BitWidth-1:0]};
    else if (a < SMIN) return {1'b1, SMIN[BitWidth-1:0]};
    else               return {1'b0, a[BitWidth-1:0]};
  endfunction

  assign accept    = strm.in_valid && strm.in_ready;
  assign out_fire  = strm.out_valid && strm.out_ready;
  assign last_beat = (beat_q == BCW'(NBEATS - 1));
  assign last_out  = (idx_q == IdxW'(OutLen - 1));
  assign idx_nx    = last_out ? '0 : idx_q + 1'b1;
  assign relu_eff  = (state_q == IDLE) ? relu_en : relu_q;

  // First beat overwrites the accumulators so no stale partial sum survives.
  always_comb begin
    for (int j = 0; j < OutLen; j++) begin
      acc_next[j] = (state_q == IDLE) ? '0 : acc_q[j];
      for (int l = 0; l < LanesIn; l++) begin
        acc_next[j] = acc_next[j] + term(
          strm.vec_in[l*BitWidth +: BitWidth],
          W[2*((int'(beat_q)*LanesIn + l)*OutLen + j) +: 2]);
      end
    end
  end

  // Next element to present: acc[0] as the drain starts, otherwise the following index.
  always_comb begin
    sel_acc = (state_q == DRAIN) ? acc_q[idx_nx] : acc_next[0];
    sel_sat = sat(sel_acc);
    sel_res = (relu_eff && sel_sat[BitWidth-1]) ? '0 : sel_sat[BitWidth-1:0];
  end

  always_comb begin
    state_d       = state_q;
    strm.in_ready = 1'b0;
    strm.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        strm.in_ready = en;
        if (accept) state_d = last_beat ? DRAIN : ACCUM;
      end
      ACCUM: begin
        strm.in_ready = en;
        busy          = 1'b1;
        if (accept && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        strm.out_valid = 1'b1;
        busy           = 1'b1;
        if (out_fire && last_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q   <= '0;
      idx_q    <= '0;
      relu_q   <= 1'b0;
      vout_q   <= '0;
      clamp_q  <= 1'b0;
      overflow <= 1'b0;
      for (int j = 0; j < OutLen; j++) acc_q[j] <= '0;
    end else begin
      if (accept) begin
        for (int j = 0; j < OutLen; j++) acc_q[j] <= acc_next[j];
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (state_q == IDLE) begin
          relu_q   <= relu_en;
          overflow <= 1'b0;
        end
        if (last_beat) begin
          idx_q   <= '0;
          vout_q  <= sel_res;
          clamp_q <= sel_sat[BitWidth];
        end
      end
      if (out_fire) begin
        overflow <= overflow | clamp_q;
        idx_q    <= idx_nx;
        if (last_out) begin
          vout_q  <= '0;
          clamp_q <= 1'b0;
        end else begin
          vout_q  <= sel_res;
          clamp_q <= sel_sat[BitWidth];
        end
      end
    end
  end

  assign strm.vec_out = vout_q;
  assign strm.out_idx = idx_q;
endmodule

// File: tb/tb_tt_um_ternary_mvm_stream.sv
// Scoreboard bench for the ternary MVM engine: driver pushes expected results, monitor pops on output handshakes.
module tb_tt_um_ternary_mvm_stream;
  localparam int InLen = 16, OutLen = 8, BW = 8, Lanes = 2, AccW = 13, NB = InLen / Lanes;

  typedef logic [BW-1:0] vec_t [InLen];
  typedef logic [BW-1:0] res_t [OutLen];

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       en = 1'b0;
  logic                       relu_en = 1'b0;
  logic [2*InLen*OutLen-1:0]  W = '0;
  logic                       busy, overflow;

  tt_um_ternary_mvm_stream_if #(.BitWidth(BW), .LanesIn(Lanes), .OutLen(OutLen)) bus ();

  tt_um_ternary_mvm_stream #(
    .InLen(InLen), .OutLen(OutLen), .BitWidth(BW), .LanesIn(Lanes), .AccWidth(AccW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .relu_en  (relu_en),
    .W        (W),
    .strm     (bus.slave),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [BW-1:0] q_val [$];
  logic [2:0]    q_idx [$];
  bit            q_ovf [$];
  bit            rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mode 0: all +1, 1: +1 even rows / -1 odd rows, 2: all -1, 3: (i+j)%3 -> 01/10/00, 4: random
  task automatic set_w(input int mode);
    logic [1:0] c;
    for (int i = 0; i < InLen; i++) begin
      for (int j = 0; j < OutLen; j++) begin
        case (mode)
          0: c = 2'b01;
          1: c = (i % 2 == 0) ? 2'b01 : 2'b11;
          2: c = 2'b11;
          3: c = ((i + j) % 3 == 0) ? 2'b01 : (((i + j) % 3 == 1) ? 2'b10 : 2'b00);
          default: c = 2'($urandom_range(0, 3));
        endcase
        W[2*(i*OutLen+j) +: 2] = c;
      end
    end
  endtask

  task automatic model(input vec_t x, input bit relu, output res_t y, output bit ovf);
    int s;
    logic [1:0] c;
    ovf = 1'b0;
    for (int j = 0; j < OutLen; j++) begin
      s = 0;
      for (int i = 0; i < InLen; i++) begin
        c = W[2*(i*OutLen+j) +: 2];
        if (c == 2'b01)      s = s + int'($signed(x[i]));
        else if (c == 2'b11) s = s - int'($signed(x[i]));
      end
      if (s > 127)       begin y[j] = 8'h7f; ovf = 1'b1; end
      else if (s < -128) begin y[j] = 8'h80; ovf = 1'b1; end
      else               y[j] = s[7:0];
      if (relu && y[j][7]) y[j] = 8'h00;
    end
  endtask

  task automatic push_vec(input res_t y, input bit ovf);
    for (int j = 0; j < OutLen; j++) begin
      q_val.push_back(y[j]);
      q_idx.push_back(3'(j));
    end
    q_ovf.push_back(ovf);
  endtask

  task automatic send_beat(input logic [Lanes*BW-1:0] d, input bit stall);
    bit ok;
    if (stall) begin
      en = 1'b0;
      bus.in_valid = 1'b1;
      bus.vec_in = d;
      repeat (3) begin
        @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
      end
      en = 1'b1;
    end
    bus.in_valid = 1'b1;
    bus.vec_in = d;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: in_ready never rose, required within 2000 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t x, input bit relu, input int gap_max,
                          input bit stall, input int nbeats);
    relu_en = relu;
    for (int b = 0; b < nbeats; b++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send_beat({x[2*b+1], x[2*b]}, stall && (b == 3));
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (!busy && q_val.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d, required 0 and 0", busy, q_val.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on each output handshake and checks hold stability under backpressure.
  initial begin
    bit            hv;
    logic [BW-1:0] hval, ev;
    logic [2:0]    hidx, ei;
    bit            eo;
    hv = 1'b0;
    forever begin
      @(negedge clk);
      if (hv && bus.out_valid) begin
        check("hold_vec_out", 32'(bus.vec_out), 32'(hval));
        check("hold_out_idx", 32'(bus.out_idx), 32'(hidx));
      end
      hv = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (q_val.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: idx %0d val %0h, required no output", bus.out_idx, bus.vec_out);
        end else begin
          ev = q_val.pop_front();
          ei = q_idx.pop_front();
          check("vec_out", 32'(bus.vec_out), 32'(ev));
          check("out_idx", 32'(bus.out_idx), 32'(ei));
          if (ei == 3'(OutLen - 1)) begin
            eo = q_ovf.pop_front();
            @(negedge clk);
            check("overflow", 32'(overflow), 32'(eo));
            check("out_valid_drop", 32'(bus.out_valid), 32'd0);
            check("out_idx_wrap", 32'(bus.out_idx), 32'd0);
          end
        end
      end else if (bus.out_valid) begin
        hv   = 1'b1;
        hval = bus.vec_out;
        hidx = bus.out_idx;
      end
    end
  end

  initial begin
    vec_t x;
    res_t y;
    bit   ovf;
    bit   ok;
    bus.in_valid = 1'b0;
    bus.vec_in   = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_vec_out", 32'(bus.vec_out), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;

    // all +1 weights, x=1..16: sum 136 saturates to 127
    set_w(0);
    for (int i = 0; i < InLen; i++) x[i] = 8'(i + 1);
    for (int j = 0; j < OutLen; j++) y[j] = 8'h7f;
    push_vec(y, 1'b1);
    send_vec(x, 1'b0, 0, 1'b0, NB);

    // alternating +/-, x=5: cancels to 0; first result one clock after last beat
    wait_idle();
    set_w(1);
    for (int i = 0; i < InLen; i++) x[i] = 8'd5;
    for (int j = 0; j < OutLen; j++) y[j] = 8'h00;
    push_vec(y, 1'b0);
    send_vec(x, 1'b0, 0, 1'b0, NB);
    @(negedge clk);
    check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    check("drain_busy", 32'(busy), 32'd1);

    // all -1 weights
    wait_idle();
    set_w(2);
    for (int i = 0; i < InLen; i++) x[i] = 8'h80;
    for (int j = 0; j < OutLen; j++) y[j] = 8'h7f;
    push_vec(y, 1'b1);
    send_vec(x, 1'b0, 0, 1'b0, NB);
    for (int i = 0; i < InLen; i++) x[i] = 8'd3;
    for (int j = 0; j < OutLen; j++) y[j] = 8'hd0;
    push_vec(y, 1'b0);
    send_vec(x, 1'b0, 0, 1'b0, NB);
    for (int j = 0; j < OutLen; j++) y[j] = 8'h00;
    push_vec(y, 1'b0);
    send_vec(x, 1'b1, 0, 1'b0, NB);
    for (int i = 0; i < InLen; i++) x[i] = 8'd127;
    push_vec(y, 1'b1);
    send_vec(x, 1'b1, 0, 1'b0, NB);

    // 10/00 codes contribute nothing; two vectors back to back
    wait_idle();
    set_w(3);
    for (int i = 0; i < InLen; i++) x[i] = 8'd7;
    y = '{8'd42, 8'd35, 8'd35, 8'd42, 8'd35, 8'd35, 8'd42, 8'd35};
    push_vec(y, 1'b0);
    send_vec(x, 1'b0, 0, 1'b0, NB);
    for (int i = 0; i < InLen; i++) x[i] = 8'hfd;
    y = '{8'hee, 8'hf1, 8'hf1, 8'hee, 8'hf1, 8'hf1, 8'hee, 8'hf1};
    push_vec(y, 1'b0);
    send_vec(x, 1'b0, 0, 1'b0, NB);

    // reset after four beats discards the partial sums
    wait_idle();
    set_w(0);
    for (int i = 0; i < InLen; i++) x[i] = 8'(i + 1);
    send_vec(x, 1'b0, 0, 1'b0, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_vec_out", 32'(bus.vec_out), 32'd0);
    check("abort_out_idx", 32'(bus.out_idx), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < InLen; i++) x[i] = 8'd2;
    for (int j = 0; j < OutLen; j++) y[j] = 8'd32;
    push_vec(y, 1'b0);
    send_vec(x, 1'b0, 0, 1'b0, NB);

    // random weights/data with input gaps, output backpressure and an en stall
    wait_idle();
    rand_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      wait_idle();
      set_w(4);
      for (int i = 0; i < InLen; i++) x[i] = 8'($urandom_range(0, 255));
      model(x, v[0], y, ovf);
      push_vec(y, ovf);
      send_vec(x, v[0], 3, v == 1, NB);
    end

    ok = 1'b0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clk);
      if (q_val.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", q_val.size());
    end
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
